multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles spent in FETCH and MEMREAD (range 0..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports op (input, 7, instruction opcode) and zero (input, 1, ALU zero flag).
REQ-005 SHALL have outputs pcwrite, adrsrc, memwrite, irwrite and regwrite, each 1 bit, acting as datapath enables and selects.
REQ-006 SHALL have outputs resultsrc, alusrca, alusrcb and aluop, each 2 bits, acting as datapath mux selects and ALU-op class.
REQ-007 SHALL have outputs immsrc (3 bits, immediate-format select to the extend unit), illegal (1 bit, undecodable-opcode flag) and state (4 bits, current state, debug).

Function
REQ-008 SHALL be a Moore FSM; every output except pcwrite, immsrc and illegal SHALL depend on state (and wait counter) only.
REQ-009 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUIWB=11.
REQ-010 SHALL transition FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, else->FETCH.
REQ-011 SHALL transition MEMADR->MEMREAD if op=0000011 else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-012 SHALL hold FETCH and MEMREAD for exactly MEM_WAIT+1 cycles using a 4-bit wait counter that clears on state entry; the state advances only when the counter equals MEM_WAIT.
REQ-013 SHALL produce these per-state outputs, with unlisted outputs 0:
- FETCH: irwrite=1 and pcupdate=1 on its last cycle only; alusrcb=10, resultsrc=10.
- DECODE: alusrca=01, alusrcb=01.
- MEMADR: alusrca=10, alusrcb=01.
- MEMREAD: adrsrc=1.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1.
- EXECUTER: alusrca=10, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: regwrite=1.
- BEQ: alusrca=10, aluop=01, branch=1.
- JAL: alusrca=01, alusrcb=10, pcupdate=1.
REQ-014 SHALL drive pcwrite = pcupdate OR (branch AND zero), combinationally.
REQ-015 SHALL decode immsrc combinationally from op: lw/I-ALU=000, sw=001, beq=010, jal=011, lui=100, any other op=000.
REQ-016 SHALL assert illegal for exactly the DECODE cycle whose op is not decodable; the FSM then returns to FETCH with no write enable asserted.

Reset
REQ-017 SHALL, while reset_n=0, force state=FETCH and wait counter=0, and force pcwrite, irwrite, regwrite, memwrite and illegal to 0 regardless of state.
REQ-018 SHALL abandon an in-flight instruction on reset assertion in any state (including mid-wait) and SHALL start FETCH cleanly on the first rising clk edge after release.

Configuration
REQ-019 SHALL, when MCCTRL_LUI_EN is defined, decode op=0110111 in DECODE to LUIWB, which drives resultsrc=11 and regwrite=1 and then goes to FETCH.
REQ-020 SHALL, when MCCTRL_LUI_EN is undefined, omit LUIWB, treat op=0110111 as illegal per REQ-016, and leave encoding 11 unused.

Verification
REQ-021 SHALL cover: MEM_WAIT=0, op=0000011 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4.
REQ-022 SHALL cover: op=0100011 -> sequence 0,1,2,5,0; memwrite=1 for exactly one cycle; immsrc=001.
REQ-023 SHALL cover: op=1100011 in BEQ with zero=1, then repeated with zero=0 -> pcwrite=1 in the BEQ cycle for zero=1, and 0 for zero=0.
REQ-024 SHALL cover: MEM_WAIT=2 -> FETCH lasts 3 cycles with irwrite=1 only on the third; MEMREAD also lasts 3 cycles.
REQ-025 SHALL cover: op=1111111 -> illegal=1 for one cycle in state 1, next state 0, no write enable asserted.
REQ-026 SHALL cover: reset_n=0 asserted mid-MEMWRITE -> memwrite drops to 0 immediately, state=0; after release, a normal lw completes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Moore-style main controller for a multicycle RV32I-subset core.
//            Sequences FETCH/DECODE/execute/writeback states and drives
//            datapath enables and mux selects. FETCH and MEMREAD are stretched
//            by MEM_WAIT extra cycles to cover slow memory.
// Params   : MEM_WAIT      - extra wait cycles in FETCH and MEMREAD (0..15)
// Options  : MCCTRL_LUI_EN - when defined, op 0110111 (lui) is decoded to
//            LUIWB; otherwise it is treated as an illegal opcode.
// Ports    : clk        in   clock, all state updates on rising edge
//            reset_n    in   asynchronous active-low reset
//            op[6:0]    in   instruction opcode
//            zero       in   ALU zero flag
//            pcwrite    out  PC write enable (pcupdate | branch & zero)
//            adrsrc     out  memory address select
//            memwrite   out  memory write enable
//            irwrite    out  instruction register write enable
//            regwrite   out  register file write enable
//            resultsrc  out  result mux select
//            alusrca    out  ALU operand A select
//            alusrcb    out  ALU operand B select
//            aluop      out  ALU operation class
//            immsrc     out  immediate format select
//            illegal    out  undecodable opcode seen in DECODE
//            state      out  current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [2:0] immsrc,
    output logic       illegal,
    output logic [3:0] state
);

    // State encodings
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BEQ      = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;
`ifdef MCCTRL_LUI_EN
    localparam logic [3:0] c_LUIWB    = 4'd11;
`endif

    // Opcodes
    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;

    localparam logic [3:0] c_WAIT_LAST = 4'(MEM_WAIT);

    logic [3:0] r_state;
    logic [3:0] r_wait;
    logic [3:0] w_dec_next;
    logic       w_op_legal;
    logic       w_wait_done;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;

    // Wait counter only runs in FETCH/MEMREAD; elsewhere it sits at zero,
    // so this compare is the "last cycle" marker of a stretched state.
    assign w_wait_done = (r_wait == c_WAIT_LAST);

    // Opcode decode used by the DECODE state
    always_comb begin
        w_op_legal = 1'b1;
        w_dec_next = c_FETCH;
        case (op)
            c_OP_LW, c_OP_SW: w_dec_next = c_MEMADR;
            c_OP_R:           w_dec_next = c_EXECUTER;
            c_OP_I:           w_dec_next = c_EXECUTEI;
            c_OP_BEQ:         w_dec_next = c_BEQ;
            c_OP_JAL:         w_dec_next = c_JAL;
`ifdef MCCTRL_LUI_EN
            c_OP_LUI:         w_dec_next = c_LUIWB;
`endif
            default:          w_op_legal = 1'b0;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_FETCH;
            r_wait  <= 4'd0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_wait_done) begin
                        r_state <= c_DECODE;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait  <= r_wait + 4'd1;
                    end
                end
                c_DECODE:   r_state <= w_dec_next;
                c_MEMADR:   r_state <= (op == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
                c_MEMREAD: begin
                    if (w_wait_done) begin
                        r_state <= c_MEMWB;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait  <= r_wait + 4'd1;
                    end
                end
                c_EXECUTER, c_EXECUTEI, c_JAL: r_state <= c_ALUWB;
                c_MEMWB, c_MEMWRITE, c_ALUWB, c_BEQ: r_state <= c_FETCH;
                default: begin
                    // Covers LUIWB when enabled and any unused encoding
                    r_state <= c_FETCH;
                    r_wait  <= 4'd0;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        case (r_state)
            c_FETCH: begin
                // IR and PC update once the memory data is valid
                w_irwrite  = w_wait_done;
                w_pcupdate = w_wait_done;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
            end
            c_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            c_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            c_MEMREAD:  adrsrc = 1'b1;
            c_MEMWB: begin
                resultsrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            c_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            c_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            c_ALUWB:    w_regwrite = 1'b1;
            c_BEQ: begin
                alusrca  = 2'b10;
                aluop    = 2'b01;
                w_branch = 1'b1;
            end
            c_JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                w_pcupdate = 1'b1;
            end
`ifdef MCCTRL_LUI_EN
            c_LUIWB: begin
                resultsrc  = 2'b11;
                w_regwrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Immediate format select, straight from the opcode
    always_comb begin
        case (op)
            c_OP_SW:  immsrc = 3'b001;
            c_OP_BEQ: immsrc = 3'b010;
            c_OP_JAL: immsrc = 3'b011;
            c_OP_LUI: immsrc = 3'b100;
            default:  immsrc = 3'b000;
        endcase
    end

    // Write enables are masked by reset_n so nothing can commit while the
    // reset is held, even in the FETCH last-cycle condition of MEM_WAIT=0.
    assign pcwrite  = reset_n & (w_pcupdate | (w_branch & zero));
    assign irwrite  = reset_n & w_irwrite;
    assign regwrite = reset_n & w_regwrite;
    assign memwrite = reset_n & w_memwrite;
    assign illegal  = reset_n & (r_state == c_DECODE) & ~w_op_legal;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Two instances run side
//            by side (MEM_WAIT=0 and MEM_WAIT=2) on shared stimulus. Directed
//            scenarios plus randomized opcodes checked against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] r_op = 7'd0;
    logic       r_zero = 1'b0;

    logic       w_pcwrite0, w_adrsrc0, w_memwrite0, w_irwrite0, w_regwrite0, w_illegal0;
    logic [1:0] w_resultsrc0, w_alusrca0, w_alusrcb0, w_aluop0;
    logic [2:0] w_immsrc0;
    logic [3:0] w_state0;

    logic       w_pcwrite2, w_adrsrc2, w_memwrite2, w_irwrite2, w_regwrite2, w_illegal2;
    logic [1:0] w_resultsrc2, w_alusrca2, w_alusrcb2, w_aluop2;
    logic [2:0] w_immsrc2;
    logic [3:0] w_state2;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle state and "last fetch cycle" flag, per instance
    int exp_st   [2][64];
    bit exp_last [2][64];
    int fill_k;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(r_op), .zero(r_zero),
        .pcwrite(w_pcwrite0), .adrsrc(w_adrsrc0), .memwrite(w_memwrite0),
        .irwrite(w_irwrite0), .regwrite(w_regwrite0), .resultsrc(w_resultsrc0),
        .alusrca(w_alusrca0), .alusrcb(w_alusrcb0), .aluop(w_aluop0),
        .immsrc(w_immsrc0), .illegal(w_illegal0), .state(w_state0)
    );

    multicycle_ctrl #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .op(r_op), .zero(r_zero),
        .pcwrite(w_pcwrite2), .adrsrc(w_adrsrc2), .memwrite(w_memwrite2),
        .irwrite(w_irwrite2), .regwrite(w_regwrite2), .resultsrc(w_resultsrc2),
        .alusrca(w_alusrca2), .alusrcb(w_alusrcb2), .aluop(w_aluop2),
        .immsrc(w_immsrc2), .illegal(w_illegal2), .state(w_state2)
    );

    logic [16:0] w_obs0, w_obs2;
    assign w_obs0 = {w_pcwrite0, w_adrsrc0, w_memwrite0, w_irwrite0, w_regwrite0,
                     w_resultsrc0, w_alusrca0, w_alusrcb0, w_aluop0, w_immsrc0, w_illegal0};
    assign w_obs2 = {w_pcwrite2, w_adrsrc2, w_memwrite2, w_irwrite2, w_regwrite2,
                     w_resultsrc2, w_alusrca2, w_alusrcb2, w_aluop2, w_immsrc2, w_illegal2};

    // ---------------- reference model ----------------
    function automatic bit op_legal(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1100011, 7'b1101111: return 1'b1;
`ifdef MCCTRL_LUI_EN
            7'b0110111: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input int idx, input int st, input bit last);
        if (fill_k < 64) begin
            exp_st[idx][fill_k]   = st;
            exp_last[idx][fill_k] = last;
            fill_k++;
        end
    endtask

    // Repeats the instruction's state walk until 64 cycles are described
    task automatic build_expect(input int idx, input int mw, input logic [6:0] o);
        fill_k = 0;
        while (fill_k < 64) begin
            for (int i = 0; i <= mw; i++) push(idx, 0, i == mw);
            push(idx, 1, 1'b0);
            case (o)
                7'b0000011: begin
                    push(idx, 2, 1'b0);
                    for (int i = 0; i <= mw; i++) push(idx, 3, 1'b0);
                    push(idx, 4, 1'b0);
                end
                7'b0100011: begin push(idx, 2, 1'b0); push(idx, 5, 1'b0); end
                7'b0110011: begin push(idx, 6, 1'b0); push(idx, 8, 1'b0); end
                7'b0010011: begin push(idx, 7, 1'b0); push(idx, 8, 1'b0); end
                7'b1100011: push(idx, 9, 1'b0);
                7'b1101111: begin push(idx, 10, 1'b0); push(idx, 8, 1'b0); end
`ifdef MCCTRL_LUI_EN
                7'b0110111: push(idx, 11, 1'b0);
`endif
                default: ;
            endcase
        end
    endtask

    function automatic logic [16:0] exp_out(input int st, input bit last,
                                            input logic z, input logic [6:0] o);
        logic pcu, br, adr, mw, ir, rw, ill;
        logic [1:0] rs, sa, sb, ao;
        logic [2:0] imm;
        pcu = 0; br = 0; adr = 0; mw = 0; ir = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; ao = 0;
        case (st)
            0:  begin ir = last; pcu = last; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; ao = 2; end
            7:  begin sa = 2; sb = 1; ao = 2; end
            8:  rw = 1;
            9:  begin sa = 2; ao = 1; br = 1; end
            10: begin sa = 1; sb = 2; pcu = 1; end
            11: begin rs = 3; rw = 1; end
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        ill = (st == 1) && !op_legal(o);
        return {pcu | (br & z), adr, mw, ir, rw, rs, sa, sb, ao, imm, ill};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Leaves the bench at cycle 0 (first FETCH cycle after release)
    task automatic start(input logic [6:0] o, input logic z);
        @(negedge clk);
        reset_n = 1'b0;
        r_op    = o;
        r_zero  = z;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        r_op    = 7'b0000011;
        r_zero  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (w_state0 !== 4'd0 || w_state2 !== 4'd0)
                $display("FAIL reset_state: got %0d/%0d want 0/0", w_state0, w_state2);
            else n_pass++;
            n_checks++;
            if ({w_pcwrite0, w_irwrite0, w_regwrite0, w_memwrite0, w_illegal0} !== 5'b0 ||
                {w_pcwrite2, w_irwrite2, w_regwrite2, w_memwrite2, w_illegal2} !== 5'b0)
                $display("FAIL reset_enables: got %b/%b want 00000",
                         {w_pcwrite0, w_irwrite0, w_regwrite0, w_memwrite0, w_illegal0},
                         {w_pcwrite2, w_irwrite2, w_regwrite2, w_memwrite2, w_illegal2});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw;
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        start(7'b0000011, 1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (w_state0 !== 4'(seq[c]))
                $display("FAIL lw_state c%0d: got %0d want %0d", c, w_state0, seq[c]);
            else n_pass++;
            n_checks++;
            if (w_regwrite0 !== (seq[c] == 4))
                $display("FAIL lw_regwrite c%0d: got %b want %b", c, w_regwrite0, seq[c] == 4);
            else n_pass++;
        end
    endtask

    task automatic test_sw;
        int seq [5] = '{0, 1, 2, 5, 0};
        int n_mw = 0;
        start(7'b0100011, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (w_memwrite0 === 1'b1) n_mw++;
            n_checks++;
            if (w_state0 !== 4'(seq[c]))
                $display("FAIL sw_state c%0d: got %0d want %0d", c, w_state0, seq[c]);
            else n_pass++;
        end
        n_checks++;
        if (n_mw != 1) $display("FAIL sw_memwrite_cycles: got %0d want 1", n_mw);
        else n_pass++;
        n_checks++;
        if (w_immsrc0 !== 3'b001) $display("FAIL sw_immsrc: got %b want 001", w_immsrc0);
        else n_pass++;
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            start(7'b1100011, 1'(z));
            tick();
            tick();
            n_checks++;
            if (w_state0 !== 4'd9 || w_pcwrite0 !== 1'(z))
                $display("FAIL beq_pcwrite z=%0d: got state %0d pcwrite %b want state 9 pcwrite %0d",
                         z, w_state0, w_pcwrite0, z);
            else n_pass++;
            n_checks++;
            if (w_immsrc0 !== 3'b010) $display("FAIL beq_immsrc: got %b want 010", w_immsrc0);
            else n_pass++;
            tick();
            n_checks++;
            if (w_state0 !== 4'd0) $display("FAIL beq_return: got %0d want 0", w_state0);
            else n_pass++;
        end
    endtask

    task automatic test_mem_wait;
        int seq [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
        bit ir  [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        start(7'b0000011, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (w_state2 !== 4'(seq[c]) || w_irwrite2 !== ir[c])
                $display("FAIL memwait c%0d: got state %0d irwrite %b want state %0d irwrite %b",
                         c, w_state2, w_irwrite2, seq[c], ir[c]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal;
        int seq [3] = '{0, 1, 0};
        start(7'b1111111, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (w_state0 !== 4'(seq[c]) || w_illegal0 !== (c == 1))
                $display("FAIL illegal c%0d: got state %0d illegal %b want state %0d illegal %b",
                         c, w_state0, w_illegal0, seq[c], c == 1);
            else n_pass++;
            n_checks++;
            if (w_regwrite0 !== 1'b0 || w_memwrite0 !== 1'b0 ||
                (c == 1 && (w_pcwrite0 !== 1'b0 || w_irwrite0 !== 1'b0)))
                $display("FAIL illegal_we c%0d: got rw%b mw%b pw%b iw%b want none",
                         c, w_regwrite0, w_memwrite0, w_pcwrite0, w_irwrite0);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_memwrite;
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        start(7'b0100011, 1'b0);
        tick(); tick(); tick();
        n_checks++;
        if (w_state0 !== 4'd5 || w_memwrite0 !== 1'b1)
            $display("FAIL midrst_pre: got state %0d memwrite %b want 5 1", w_state0, w_memwrite0);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (w_memwrite0 !== 1'b0 || w_state0 !== 4'd0 || w_state2 !== 4'd0)
            $display("FAIL midrst_async: got memwrite %b state %0d/%0d want 0 0/0",
                     w_memwrite0, w_state0, w_state2);
        else n_pass++;
        @(negedge clk);
        r_op = 7'b0000011;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (w_state0 !== 4'(seq[c]) || w_regwrite0 !== (seq[c] == 4))
                $display("FAIL midrst_lw c%0d: got state %0d regwrite %b want %0d %b",
                         c, w_state0, w_regwrite0, seq[c], seq[c] == 4);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b0110111};
        logic [6:0] o;
        logic [16:0] e;
        for (int it = 0; it < 25; it++) begin
            int pick = $urandom_range(0, 7);
            o = (pick == 7) ? 7'($urandom) : ops[pick];
            build_expect(0, 0, o);
            build_expect(1, 2, o);
            start(o, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 16; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    r_zero = 1'($urandom_range(0, 1));
                    #1;
                end
                e = exp_out(exp_st[0][c], exp_last[0][c], r_zero, o);
                n_checks++;
                if (w_state0 !== 4'(exp_st[0][c]) || w_obs0 !== e)
                    $display("FAIL rand_mw0 op=%b c%0d: got state %0d out %b want state %0d out %b",
                             o, c, w_state0, w_obs0, exp_st[0][c], e);
                else n_pass++;
                e = exp_out(exp_st[1][c], exp_last[1][c], r_zero, o);
                n_checks++;
                if (w_state2 !== 4'(exp_st[1][c]) || w_obs2 !== e)
                    $display("FAIL rand_mw2 op=%b c%0d: got state %0d out %b want state %0d out %b",
                             o, c, w_state2, w_obs2, exp_st[1][c], e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_mem_wait();
        test_illegal();
        test_reset_mid_memwrite();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
